// File: rtl/bcd_pkg.sv
// Shared code constants, FSM state type and digit-code helpers for the
// sequential BCD-to-binary converter.
package bcd_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hA;
  localparam logic [3:0] BCD_MINUS = 4'hB;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StFin,
    StDone
  } bcd_state_e;

  // Blank is a legal numeric code that contributes a zero digit.
  function automatic logic is_numeric(input logic [3:0] code);
    return (code <= 4'd9) || (code == BCD_BLANK);
  endfunction

  function automatic logic [3:0] digit_val(input logic [3:0] code);
    return (code <= 4'd9) ? code : 4'd0;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Input word and result handshakes of the BCD-to-binary converter.
// master = digit buffer / consumer side, slave = converter.
interface bcd_to_bin_seq_if #(
  parameter int unsigned BITS   = 11,
  parameter int unsigned DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BITS-1:0]       binout;
  logic                  err;
  logic                  ovf;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, binout, err, ovf
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, binout, err, ovf
  );
endinterface

// File: rtl/bcd_digit_mac.sv
// One multiply-by-10-and-add step of the BCD accumulator, clamped to the
// sign-dependent magnitude limit.
module bcd_digit_mac #(
  parameter int unsigned BITS = 11
) (
  input  logic [BITS-1:0] acc_i,
  input  logic [3:0]      digit_i,
  input  logic            neg_i,
  output logic [BITS-1:0] acc_o,
  output logic            ovf_o
);

  localparam int unsigned W = BITS + 4;

  logic [W-1:0] acc_ext;
  logic [W-1:0] wide;
  logic [W-1:0] limit;

  always_comb begin
    acc_ext = W'(acc_i);
    wide    = (acc_ext << 3) + (acc_ext << 1) + W'(digit_i);
    // Negative words may reach one more than positive ones: -2^(BITS-1).
    limit   = neg_i ? (W'(1) << (BITS - 1)) : ((W'(1) << (BITS - 1)) - W'(1));
    ovf_o   = wide > limit;
    acc_o   = ovf_o ? limit[BITS-1:0] : wide[BITS-1:0];
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-signed-binary converter: latches a word of display codes,
// folds in one digit per clock, then applies the sign with saturation.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BITS      = 11,
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SIGN_SLOT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_to_bin_seq_if.slave bus
);

  localparam int NUM  = int'(DIGITS) - int'(SIGN_SLOT);
  localparam int IdxW = (NUM > 1) ? $clog2(NUM) : 1;

  if (NUM < 1) begin : g_num_check
    $error("bcd_to_bin_seq: at least one numeric slot is required");
  end

  bcd_state_e          state_q,  state_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [BITS-1:0]     acc_q,    acc_d;
  logic [IdxW-1:0]     idx_q,    idx_d;
  logic                neg_q,    neg_d;
  logic                err_q,    err_d;
  logic                ovf_q,    ovf_d;
  logic [BITS-1:0]     binout_q, binout_d;
  logic                erro_q,   erro_d;
  logic                ovfo_q,   ovfo_d;

  logic [3:0]      code;
  logic [3:0]      digit;
  logic [3:0]      sign_code;
  logic [BITS-1:0] mac_acc;
  logic            mac_ovf;

  assign code      = shadow_q[4*int'(idx_q) +: 4];
  assign digit     = digit_val(code);
  assign sign_code = (SIGN_SLOT != 0) ? bus.bcd_in[4*DIGITS-1 -: 4] : 4'h0;

  bcd_digit_mac #(
    .BITS (BITS)
  ) u_mac (
    .acc_i   (acc_q),
    .digit_i (digit),
    .neg_i   (neg_q),
    .acc_o   (mac_acc),
    .ovf_o   (mac_ovf)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    neg_d    = neg_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    binout_d = binout_q;
    erro_d   = erro_q;
    ovfo_d   = ovfo_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          shadow_d = bus.bcd_in;
          acc_d    = '0;
          idx_d    = IdxW'(NUM - 1);
          // Sign is fixed at accept time so the clamp limit never changes mid-word.
          neg_d    = (sign_code == BCD_MINUS);
          err_d    = (sign_code > BCD_MINUS);
          ovf_d    = 1'b0;
          state_d  = StConv;
        end
      end
      StConv: begin
        acc_d = mac_acc;
        ovf_d = ovf_q | mac_ovf;
        err_d = err_q | ~is_numeric(code);
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) state_d = StFin;
      end
      StFin: begin
        if (err_q) begin
          binout_d = '0;
          erro_d   = 1'b1;
          ovfo_d   = 1'b0;
        end else begin
          // acc == 2^(BITS-1) only when negative; its negation is the minimum value.
          binout_d = neg_q ? -acc_q : acc_q;
          erro_d   = 1'b0;
          ovfo_d   = ovf_q;
        end
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      binout_q <= '0;
      erro_q   <= 1'b0;
      ovfo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      binout_q <= binout_d;
      erro_q   <= erro_d;
      ovfo_q   <= ovfo_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.binout    = binout_q;
  assign bus.err       = erro_q;
  assign bus.ovf       = ovfo_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench: an 11-bit and an 8-bit converter (4 slots, sign slot)
// checked against a decimal-arithmetic reference model.
module tb_bcd_to_bin_seq;

  localparam int NUM = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_to_bin_seq_if #(.BITS(11), .DIGITS(4)) b11 ();
  bcd_to_bin_seq_if #(.BITS(8),  .DIGITS(4)) b8 ();

  bcd_to_bin_seq #(.BITS(11), .DIGITS(4), .SIGN_SLOT(1)) dut11 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b11)
  );

  bcd_to_bin_seq #(.BITS(8), .DIGITS(4), .SIGN_SLOT(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Returns {ovf, err, binout (zero-extended to 11 bits)}.
  function automatic logic [12:0] ref_model(input int bits, input logic [15:0] w);
    int mag, lim, val, mask;
    bit neg, e, ov;
    logic [3:0] c;
    c   = w[15:12];
    neg = (c == 4'hB);
    e   = (c >= 4'hC);
    mag = 0;
    for (int i = 2; i >= 0; i--) begin
      c = w[i*4 +: 4];
      if (c > 4'hA) e = 1'b1;
      mag = mag * 10 + ((c <= 4'h9) ? int'(c) : 0);
    end
    if (e) return {1'b0, 1'b1, 11'd0};
    lim  = neg ? (1 << (bits - 1)) : (1 << (bits - 1)) - 1;
    ov   = (mag > lim);
    if (ov) mag = lim;
    val  = neg ? -mag : mag;
    mask = (1 << bits) - 1;
    return {ov, 1'b0, 11'(val & mask)};
  endfunction

  function automatic logic [3:0] rnd_code();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 12) return 4'($urandom_range(0, 9));
    if (r < 15) return 4'hA;
    if (r < 17) return 4'hB;
    return 4'($urandom_range(12, 15));
  endfunction

  task automatic drive(input bit w8, input logic v, input logic [15:0] w, input logic ordy);
    if (w8) begin
      b8.in_valid = v; b8.bcd_in = w; b8.out_ready = ordy;
    end else begin
      b11.in_valid = v; b11.bcd_in = w; b11.out_ready = ordy;
    end
  endtask

  task automatic sample(input bit w8, output logic ir, output logic ov, output logic [12:0] res);
    if (w8) begin
      ir = b8.in_ready; ov = b8.out_valid; res = {b8.ovf, b8.err, 3'b000, b8.binout};
    end else begin
      ir = b11.in_ready; ov = b11.out_valid; res = {b11.ovf, b11.err, b11.binout};
    end
  endtask

  // Full transaction. lat counts rising edges with the accepting edge as 1.
  task automatic convert(input bit w8, input logic [15:0] w, input int hold,
                         output logic [12:0] res, output int lat, output bit busy_ok);
    logic ir, ov;
    logic [12:0] cur;
    int guard;
    busy_ok = 1'b1;
    drive(w8, 1'b1, w, 1'b0);
    sample(w8, ir, ov, cur);
    guard = 0;
    while (!ir && guard < 20) begin
      @(posedge clk); #1; sample(w8, ir, ov, cur); guard++;
    end
    @(posedge clk); #1;
    drive(w8, 1'b0, 16'($urandom), 1'b0);
    lat = 1;
    sample(w8, ir, ov, cur);
    while (!ov && lat < 30) begin
      if (ir) busy_ok = 1'b0;
      @(posedge clk); #1; lat++; sample(w8, ir, ov, cur);
    end
    if (ir) busy_ok = 1'b0;
    res = cur;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1; sample(w8, ir, ov, cur);
      if (!ov || ir || cur !== res) busy_ok = 1'b0;
    end
    drive(w8, 1'b0, 16'h0000, 1'b1);
    @(posedge clk); #1;
    drive(w8, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_reset();
    logic ir, ov;
    logic [12:0] r;
    for (int k = 0; k < 2; k++) begin
      sample(k != 0, ir, ov, r);
      n_checks++;
      if ({ir, ov, r} !== {1'b1, 1'b0, 13'd0}) $display("FAIL reset_state dut%0d: got %b want %b", k, {ir, ov, r}, {1'b1, 1'b0, 13'd0});
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    logic [12:0] r; int lat; bit ok;
    convert(1'b0, 16'hB123, 0, r, lat, ok);
    n_checks++;
    if (r !== {2'b00, 11'h785}) $display("FAIL basic_B123: got %h want %h", r, {2'b00, 11'h785});
    else n_pass++;
    n_checks++;
    if (lat !== NUM + 2) $display("FAIL basic_latency: got %0d want %0d", lat, NUM + 2);
    else n_pass++;
    n_checks++;
    if (!ok) $display("FAIL basic_busy_ready: got 0 want 1");
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic ir, ov; logic [12:0] cur, r1, r2;
    bit got1, busy_ok; int cyc, guard;
    busy_ok = 1'b1; got1 = 1'b0; r1 = '0; r2 = '0;
    drive(1'b0, 1'b1, 16'hA999, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'hAA07, 1'b1);
    cyc = 1;
    sample(1'b0, ir, ov, cur);
    while (!(ir && got1) && cyc < 40) begin
      if (ir) busy_ok = 1'b0;
      if (ov && !got1) begin r1 = cur; got1 = 1'b1; end
      @(posedge clk); #1; cyc++; sample(1'b0, ir, ov, cur);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    guard = 0;
    sample(1'b0, ir, ov, cur);
    while (!ov && guard < 30) begin
      if (ir) busy_ok = 1'b0;
      @(posedge clk); #1; guard++; sample(1'b0, ir, ov, cur);
    end
    r2 = cur;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (r1 !== ref_model(11, 16'hA999)) $display("FAIL b2b_first: got %h want %h", r1, ref_model(11, 16'hA999));
    else n_pass++;
    n_checks++;
    if (r2 !== ref_model(11, 16'hAA07)) $display("FAIL b2b_second: got %h want %h", r2, ref_model(11, 16'hAA07));
    else n_pass++;
    n_checks++;
    if (cyc !== NUM + 3) $display("FAIL b2b_period: got %0d want %0d", cyc, NUM + 3);
    else n_pass++;
    n_checks++;
    if (!busy_ok) $display("FAIL b2b_in_ready_low: got 0 want 1");
    else n_pass++;
  endtask

  task automatic test_errors();
    logic [15:0] words [3];
    logic [12:0] r; int lat; bit ok;
    words[0] = 16'hA1C3; words[1] = 16'hA1B3; words[2] = 16'hF123;
    for (int i = 0; i < 3; i++) begin
      convert(1'b0, words[i], 0, r, lat, ok);
      n_checks++;
      if (r !== {1'b0, 1'b1, 11'd0}) $display("FAIL err_word_%h: got %h want %h", words[i], r, {1'b0, 1'b1, 11'd0});
      else n_pass++;
    end
  endtask

  task automatic test_sat8();
    logic [15:0] words [3];
    logic [12:0] want [3];
    logic [12:0] r; int lat; bit ok;
    words[0] = 16'hA200; want[0] = {1'b1, 1'b0, 11'd127};
    words[1] = 16'hB128; want[1] = {1'b0, 1'b0, 11'h080};
    words[2] = 16'hB129; want[2] = {1'b1, 1'b0, 11'h080};
    for (int i = 0; i < 3; i++) begin
      convert(1'b1, words[i], 0, r, lat, ok);
      n_checks++;
      if (r !== want[i]) $display("FAIL sat8_%h: got %h want %h", words[i], r, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [12:0] r, cur; int lat; bit ok; logic ir, ov;
    convert(1'b0, 16'hA321, 10, r, lat, ok);
    sample(1'b0, ir, ov, cur);
    n_checks++;
    if (!ok) $display("FAIL bp_stable_hold: got 0 want 1");
    else n_pass++;
    n_checks++;
    if ({ir, ov} !== 2'b10) $display("FAIL bp_release_idle: got %b want 10", {ir, ov});
    else n_pass++;
    n_checks++;
    if (cur !== ref_model(11, 16'hA321)) $display("FAIL bp_outputs_kept: got %h want %h", cur, ref_model(11, 16'hA321));
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic ir, ov; logic [12:0] r; int lat; bit ok;
    drive(1'b0, 1'b1, 16'hA555, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    test_reset();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    convert(1'b0, 16'hA042, 0, r, lat, ok);
    n_checks++;
    if (r !== {2'b00, 11'd42}) $display("FAIL rst_then_A042: got %h want %h", r, {2'b00, 11'd42});
    else n_pass++;
    sample(1'b0, ir, ov, r);
  endtask

  task automatic test_random();
    logic [15:0] w; logic [12:0] r, exp; int lat; bit ok, w8;
    for (int i = 0; i < 60; i++) begin
      w8 = (i % 2) != 0;
      w  = {rnd_code(), rnd_code(), rnd_code(), rnd_code()};
      exp = ref_model(w8 ? 8 : 11, w);
      convert(w8, w, int'($urandom_range(0, 3)), r, lat, ok);
      n_checks++;
      if (r !== exp) $display("FAIL rand_%0d_%h dut%0d: got %h want %h", i, w, w8, r, exp);
      else n_pass++;
      n_checks++;
      if (lat !== NUM + 2 || !ok) $display("FAIL rand_timing_%0d: got lat %0d ok %0d want lat %0d ok 1", i, lat, ok, NUM + 2);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    #12;
    test_reset();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_sat8();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
